enc_conditioner: RTL and testbench



---
 rtl/enc_pkg.sv | 6 +
 rtl/enc_conditioner_debounce_chan.sv | 55 +++++
 rtl/enc_conditioner.sv | 61 ++++++
 tb/tb_enc_conditioner.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/enc_pkg.sv
// Shared constants for the quadrature encoder input conditioner.
package enc_pkg;
   localparam int   DEBOUNCE_DEFAULT = 50000;
   localparam int   ENC_ERR_W        = 8;
   localparam logic IDLE_LEVEL       = 1'b1;
endpackage

// File: rtl/enc_conditioner_debounce_chan.sv
// One encoder channel: two-flop synchroniser, mismatch counter and clean output level.
module debounce_chan
   import enc_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
   input  logic clk_i,
   input  logic reset_i,
   input  logic raw_i,
   output logic level_o,
   output logic upd_o
);
   localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CW-1:0] TERM = CW'(DEBOUNCE_CYCLES - 1);

   logic          s1_q, s2_q;
   logic          out_q, out_d;
   logic          upd_q, upd_d;
   logic [CW-1:0] cnt_q, cnt_d;

   // Any sample matching the current level restarts the count, so bounces never accumulate.
   always_comb begin
      cnt_d = cnt_q;
      out_d = out_q;
      upd_d = 1'b0;
      if (s2_q == out_q) begin
         cnt_d = '0;
      end else if (cnt_q == TERM) begin
         out_d = s2_q;
         cnt_d = '0;
         upd_d = 1'b1;
      end else begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         s1_q  <= IDLE_LEVEL;
         s2_q  <= IDLE_LEVEL;
         out_q <= IDLE_LEVEL;
         upd_q <= 1'b0;
         cnt_q <= '0;
      end else begin
         s1_q  <= raw_i;
         s2_q  <= s1_q;
         out_q <= out_d;
         upd_q <= upd_d;
         cnt_q <= cnt_d;
      end
   end

   assign level_o = out_q;
   assign upd_o   = upd_q;
endmodule

// File: rtl/enc_conditioner.sv
// Encoder input conditioner: per-channel debounce, change/illegal-jump pulses and a
// saturating illegal-jump counter.
module enc_conditioner
   import enc_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
   parameter int ERR_W           = ENC_ERR_W
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             a_raw,
   input  logic             b_raw,
   input  logic             clr_err,
   output logic             a,
   output logic             b,
   output logic             changed,
   output logic             err,
   output logic [ERR_W-1:0] err_count
);
   logic             upd_a, upd_b;
   logic [ERR_W-1:0] err_cnt_q, err_cnt_d;

   debounce_chan #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_chan_a (
      .clk_i   (clk),
      .reset_i (reset),
      .raw_i   (a_raw),
      .level_o (a),
      .upd_o   (upd_a)
   );

   debounce_chan #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_chan_b (
      .clk_i   (clk),
      .reset_i (reset),
      .raw_i   (b_raw),
      .level_o (b),
      .upd_o   (upd_b)
   );

   // Strobes are already registered in the channels, so these pulses line up with a/b.
   assign changed = upd_a | upd_b;
   assign err     = upd_a & upd_b;

   always_comb begin
      err_cnt_d = err_cnt_q;
      if (clr_err) begin
         err_cnt_d = '0;
      end else if (err && (err_cnt_q != '1)) begin
         err_cnt_d = err_cnt_q + ERR_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         err_cnt_q <= '0;
      end else begin
         err_cnt_q <= err_cnt_d;
      end
   end

   assign err_count = err_cnt_q;
endmodule

// File: tb/tb_enc_conditioner.sv
// Self-checking bench for enc_conditioner with a short debounce window.
module tb_enc_conditioner;
   localparam int DC      = 4;
   localparam int ERR_W   = 8;
   localparam int ERR_MAX = (1 << ERR_W) - 1;

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic             a_raw = 1'b1;
   logic             b_raw = 1'b1;
   logic             clr_err = 1'b0;
   logic             a, b, changed, err;
   logic [ERR_W-1:0] err_count;

   int n_cmp = 0;
   int n_bad = 0;

   enc_conditioner #(.DEBOUNCE_CYCLES(DC), .ERR_W(ERR_W)) dut (
      .clk       (clk),
      .reset     (reset),
      .a_raw     (a_raw),
      .b_raw     (b_raw),
      .clr_err   (clr_err),
      .a         (a),
      .b         (b),
      .changed   (changed),
      .err       (err),
      .err_count (err_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // A channel flips once the last DC synchronised samples all disagree with its level.
   bit m_pipe_a[2], m_pipe_b[2];
   bit win_a[$], win_b[$];
   bit m_a = 1'b1, m_b = 1'b1, m_changed, m_err;
   int m_errc;

   function automatic bit all_differ(input bit q[$], input bit lvl);
      if (q.size() < DC) return 1'b0;
      foreach (q[i]) if (q[i] == lvl) return 1'b0;
      return 1'b1;
   endfunction

   always @(posedge clk) begin
      bit fa, fb;
      fa = 1'b0;
      fb = 1'b0;
      if (reset) begin
         m_pipe_a = '{1'b1, 1'b1};
         m_pipe_b = '{1'b1, 1'b1};
         win_a.delete();
         win_b.delete();
         m_a = 1'b1; m_b = 1'b1;
         m_changed = 1'b0; m_err = 1'b0; m_errc = 0;
      end else begin
         win_a.push_back(m_pipe_a[1]);
         win_b.push_back(m_pipe_b[1]);
         if (win_a.size() > DC) void'(win_a.pop_front());
         if (win_b.size() > DC) void'(win_b.pop_front());
         fa = all_differ(win_a, m_a);
         fb = all_differ(win_b, m_b);
         m_pipe_a[1] = m_pipe_a[0]; m_pipe_a[0] = a_raw;
         m_pipe_b[1] = m_pipe_b[0]; m_pipe_b[0] = b_raw;
         if (clr_err) m_errc = 0;
         else if (m_err) m_errc = (m_errc < ERR_MAX) ? m_errc + 1 : ERR_MAX;
         if (fa) m_a = ~m_a;
         if (fb) m_b = ~m_b;
         m_changed = fa | fb;
         m_err     = fa & fb;
      end
      #1;
      chk("a", {31'd0, a}, {31'd0, m_a});
      chk("b", {31'd0, b}, {31'd0, m_b});
      chk("changed", {31'd0, changed}, {31'd0, m_changed});
      chk("err", {31'd0, err}, {31'd0, m_err});
      chk("err_count", {24'd0, err_count}, m_errc);
   end

   // ---------------- driver ----------------
   task automatic step(input bit ra, input bit rb, input bit rst, input bit clr);
      @(negedge clk);
      a_raw = ra; b_raw = rb; reset = rst; clr_err = clr;
      @(posedge clk);
      #2;
   endtask

   initial begin
      bit lvl, la, lb;
      // 1. reset with random raw pins
      repeat (3) step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1, 1'b0);
      step(1'b1, 1'b1, 1'b0, 1'b0);
      chk("rst_a", {31'd0, a}, 32'd1);
      chk("rst_b", {31'd0, b}, 32'd1);
      chk("rst_changed", {31'd0, changed}, 32'd0);
      chk("rst_err", {31'd0, err}, 32'd0);
      chk("rst_err_count", {24'd0, err_count}, 32'd0);
      repeat (4) step(1'b1, 1'b1, 1'b0, 1'b0);

      // 2. clean falling edge on A: captured at edge k, a updates at edge k+5
      repeat (5) step(1'b0, 1'b1, 1'b0, 1'b0);
      chk("clean_a_before", {31'd0, a}, 32'd1);
      step(1'b0, 1'b1, 1'b0, 1'b0);
      chk("clean_a_after", {31'd0, a}, 32'd0);
      chk("clean_changed", {31'd0, changed}, 32'd1);
      chk("clean_err", {31'd0, err}, 32'd0);
      chk("clean_b", {31'd0, b}, 32'd1);
      step(1'b0, 1'b1, 1'b0, 1'b0);
      chk("clean_changed_width", {31'd0, changed}, 32'd0);

      // 3. bounce: 3 low / 1 high never reaches the output
      repeat (8) step(1'b1, 1'b1, 1'b0, 1'b0);
      for (int r = 0; r < 20; r++) begin
         repeat (3) begin
            step(1'b0, 1'b1, 1'b0, 1'b0);
            chk("bounce_changed", {31'd0, changed}, 32'd0);
         end
         step(1'b1, 1'b1, 1'b0, 1'b0);
         chk("bounce_changed", {31'd0, changed}, 32'd0);
      end
      chk("bounce_a", {31'd0, a}, 32'd1);
      repeat (5) step(1'b0, 1'b1, 1'b0, 1'b0);
      chk("bounce_hold_a_before", {31'd0, a}, 32'd1);
      step(1'b0, 1'b1, 1'b0, 1'b0);
      chk("bounce_hold_a_after", {31'd0, a}, 32'd0);

      // 4. simultaneous jump, then saturation
      repeat (8) step(1'b1, 1'b1, 1'b0, 1'b0);
      repeat (5) step(1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b0);
      chk("jump_err", {31'd0, err}, 32'd1);
      chk("jump_changed", {31'd0, changed}, 32'd1);
      chk("jump_ab", {30'd0, a, b}, 32'd0);
      step(1'b0, 1'b0, 1'b0, 1'b0);
      chk("jump_err_count", {24'd0, err_count}, 32'd1);
      lvl = 1'b0;
      for (int j = 0; j < 300; j++) begin
         lvl = ~lvl;
         repeat (6) step(lvl, lvl, 1'b0, 1'b0);
      end
      step(lvl, lvl, 1'b0, 1'b0);
      chk("sat_err_count", {24'd0, err_count}, 32'd255);

      // 5. clear wins over a simultaneous increment
      repeat (2) step(1'b1, 1'b1, 1'b1, 1'b0);
      repeat (3) step(1'b1, 1'b1, 1'b0, 1'b0);
      lvl = 1'b1;
      for (int j = 0; j < 7; j++) begin
         lvl = ~lvl;
         repeat (6) step(lvl, lvl, 1'b0, 1'b0);
      end
      lvl = ~lvl;
      repeat (6) step(lvl, lvl, 1'b0, 1'b0);
      chk("clr_pre_count", {24'd0, err_count}, 32'd7);
      chk("clr_err_pulse", {31'd0, err}, 32'd1);
      step(lvl, lvl, 1'b0, 1'b1);
      chk("clr_count", {24'd0, err_count}, 32'd0);
      step(lvl, lvl, 1'b0, 1'b0);

      // 6. reset in the middle of a debounce
      repeat (4) step(1'b1, 1'b1, 1'b0, 1'b0);
      repeat (4) step(1'b0, 1'b1, 1'b0, 1'b0);
      repeat (2) step(1'b0, 1'b1, 1'b1, 1'b0);
      chk("midrst_a", {31'd0, a}, 32'd1);
      repeat (5) step(1'b0, 1'b1, 1'b0, 1'b0);
      chk("midrst_a_before", {31'd0, a}, 32'd1);
      step(1'b0, 1'b1, 1'b0, 1'b0);
      chk("midrst_a_after", {31'd0, a}, 32'd0);

      // 7. randomized traffic with glitches, skew, clears and resets
      la = 1'b0; lb = 1'b1;
      for (int i = 0; i < 4000; i++) begin
         case ($urandom_range(0, 9))
            0: la = ~la;
            1: lb = ~lb;
            2: begin la = ~la; lb = ~lb; end
            default: ;
         endcase
         step(la, lb, ($urandom_range(0, 299) == 0), ($urandom_range(0, 39) == 0));
      end
      repeat (4) step(la, lb, 1'b0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
